// File: rtl/sprite_rom_if.sv
// sprite_rom_if: requester-side and ROM-side signals of the sprite ROM arbiter
interface sprite_rom_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 5
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0] gnt;
  logic priority_lock;
  logic hold;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_data;
  logic [NUM_REQ-1:0] rd_valid;
  logic [DATA_W-1:0] rd_data;
  modport slave(
    input req, req_addr, priority_lock, hold, rom_data,
    output gnt, rom_address, rd_valid, rd_data
  );
  modport master(
    output req, req_addr, priority_lock, hold, rom_data,
    input gnt, rom_address, rd_valid, rd_data
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one synchronous sprite ROM among NUM_REQ requesters,
// returning data with a fixed tagged latency of ROM_LATENCY+1 cycles
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 5,
  parameter int ROM_LATENCY = 1
) (
  input logic Clk,
  input logic Reset,
  sprite_rom_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int L = ROM_LATENCY;
  if (NUM_REQ < 2 || NUM_REQ > 8 || ROM_LATENCY < 1 || ROM_LATENCY > 3) begin : g_bad_cfg
    $error("sprite_rom_arbiter: NUM_REQ must be 2..8 and ROM_LATENCY 1..3");
  end
  logic [IW-1:0] last_q, last_d, rr, win;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [L:0] vld_q, vld_d;
  logic [IW-1:0] tag_q [L+1];
  logic found, hs;
  int idx;
  always_comb begin
    rr = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && bus.req[idx]) begin
        rr = IW'(idx);
        found = 1'b1;
      end
    end
  end
  assign win = (bus.priority_lock && bus.req[0]) ? '0 : rr;
  assign bus.gnt = (Reset || bus.hold || !found) ? '0 : NUM_REQ'(1) << win;
  assign hs = |(bus.req & bus.gnt);
  assign last_d = hs ? win : last_q;
  assign addr_d = hs ? bus.req_addr[win*ADDR_W +: ADDR_W] : addr_q;
  assign vld_d = {vld_q[L-1:0], hs};
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_q <= IW'(NUM_REQ - 1);
      addr_q <= '0;
      vld_q <= '0;
    end else begin
      last_q <= last_d;
      addr_q <= addr_d;
      vld_q <= vld_d;
    end
  end
  // tags need no reset: the valid bits alone qualify them
  always_ff @(posedge Clk) begin
    tag_q[0] <= win;
    for (int k = 1; k <= L; k++) tag_q[k] <= tag_q[k-1];
  end
  assign bus.rom_address = addr_q;
  assign bus.rd_valid = (vld_q[L] && !Reset) ? NUM_REQ'(1) << tag_q[L] : '0;
  assign bus.rd_data = bus.rom_data;
endmodule
